// File: rtl/vx_sfu_csr_responder_pkg.sv
// CSR address map, fflags layout and shared helpers for the SFU CSR responder.
package VX_gpu_pkg;

  localparam logic [11:0] CSR_FFLAGS       = 12'h001;
  localparam logic [11:0] CSR_FRM          = 12'h002;
  localparam logic [11:0] CSR_FCSR         = 12'h003;
  localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
  localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
  localparam logic [11:0] CSR_CYCLE        = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
  localparam logic [11:0] CSR_INSTRET      = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH     = 12'hC82;
  localparam logic [11:0] CSR_THREAD_ID    = 12'hCC0;
  localparam logic [11:0] CSR_WARP_ID      = 12'hCC1;
  localparam logic [11:0] CSR_CORE_ID      = 12'hCC2;
  localparam logic [11:0] CSR_ACTIVE_WARPS = 12'hCC3;

  localparam int FRM_BITS = 3;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  // Width of an index into x items; never below one bit.
  function automatic int log2up(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/vx_sfu_csr_responder_if.sv
// SFU CSR request/response bundle: one read port and one write port per cycle.
interface VX_sfu_csr_if #(
  parameter int NUM_LANES  = 4,
  parameter int NW_WIDTH   = 2,
  parameter int PID_WIDTH  = 1,
  parameter int XLEN       = 32,
  parameter int UUID_WIDTH = 44
);
  logic                            read_enable;
  logic [UUID_WIDTH-1:0]           read_uuid;
  logic [NW_WIDTH-1:0]             read_wid;
  logic [NUM_LANES-1:0]            read_tmask;
  logic [PID_WIDTH-1:0]            read_pid;
  logic [11:0]                     read_addr;
  logic [NUM_LANES-1:0][XLEN-1:0]  read_data;

  logic                            write_enable;
  logic [UUID_WIDTH-1:0]           write_uuid;
  logic [NW_WIDTH-1:0]             write_wid;
  logic [NUM_LANES-1:0]            write_tmask;
  logic [PID_WIDTH-1:0]            write_pid;
  logic [11:0]                     write_addr;
  logic [NUM_LANES-1:0][XLEN-1:0]  write_data;

  modport master (
    output read_enable, read_uuid, read_wid, read_tmask, read_pid, read_addr,
    input  read_data,
    output write_enable, write_uuid, write_wid, write_tmask, write_pid, write_addr, write_data
  );

  modport slave (
    input  read_enable, read_uuid, read_wid, read_tmask, read_pid, read_addr,
    output read_data,
    input  write_enable, write_uuid, write_wid, write_tmask, write_pid, write_addr, write_data
  );
endinterface

// File: rtl/vx_sfu_csr_responder_counter64.sv
// 64-bit machine counter: per-half CSR write overrides the increment for that cycle.
module vx_csr_counter64 #(
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INC_W-1:0] inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      cnt_o
);
  logic [63:0] cnt_q, cnt_d;

  // Written half is replaced, the other half holds; otherwise count up.
  always_comb begin
    cnt_d = cnt_q + 64'(inc_i);
    if (wr_lo_i || wr_hi_i) begin
      cnt_d = cnt_q;
      if (wr_lo_i) cnt_d[31:0]  = wdata_i[31:0];
      if (wr_hi_i) cnt_d[63:32] = wdata_i[63:32];
    end
  end

  // Counter register, cleared while reset is low.
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/vx_sfu_csr_responder.sv
// SFU CSR slave: counters, per-thread mscratch, per-warp FP status, identity CSRs.
// Optional: SFU_CSR_FCSR_EN adds per-warp fflags/frm storage and FPU flag accumulation.
module vx_sfu_csr_responder
  import VX_gpu_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NUM_LANES   = 4,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 8,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = log2up(NUM_WARPS),
  parameter int PID_WIDTH   = log2up(NUM_THREADS / NUM_LANES),
  parameter int CC_WIDTH    = log2up(NUM_THREADS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  VX_sfu_csr_if.slave          csr_if,
  input  logic                 commit_valid,
  input  logic [CC_WIDTH-1:0]  commit_count,
  input  logic                 fpu_fflags_valid,
  input  logic [NW_WIDTH-1:0]  fpu_fflags_wid,
  input  logic [4:0]           fpu_fflags,
  input  logic [NUM_WARPS-1:0] active_warps
);
  localparam int TID_W = log2up(NUM_THREADS);
  localparam bit X32   = (XLEN == 32);

  logic [11:0]      waddr, raddr;
  logic [XLEN-1:0]  wsel_data;
  logic             wr_any;
  logic [63:0]      cnt_wdata, mcyc, mins;
  logic             cyc_wlo, cyc_whi, ins_wlo, ins_whi;
  logic [4:0]       rd_ff;
  logic [2:0]       rd_frm;
  logic [XLEN-1:0]  shared_rd;
  logic             unused_ok;

  assign waddr  = csr_if.write_addr;
  assign raddr  = csr_if.read_addr;
  assign wr_any = csr_if.write_enable && (|csr_if.write_tmask);

  // Scalar (per-warp/per-core) writes take the lowest enabled lane's data.
  always_comb begin
    wsel_data = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--)
      if (csr_if.write_tmask[l]) wsel_data = csr_if.write_data[l];
  end

  // With XLEN=64 the low address covers the full counter; the *h addresses are inert.
  assign cnt_wdata = X32 ? {2{32'(wsel_data)}} : 64'(wsel_data);
  assign cyc_wlo   = wr_any && (waddr == CSR_MCYCLE);
  assign cyc_whi   = wr_any && (X32 ? (waddr == CSR_MCYCLEH) : (waddr == CSR_MCYCLE));
  assign ins_wlo   = wr_any && (waddr == CSR_MINSTRET);
  assign ins_whi   = wr_any && (X32 ? (waddr == CSR_MINSTRETH) : (waddr == CSR_MINSTRET));

  vx_csr_counter64 #(.INC_W(1)) u_mcycle (
    .clk(clk), .reset(reset), .inc_i(1'b1),
    .wr_lo_i(cyc_wlo), .wr_hi_i(cyc_whi), .wdata_i(cnt_wdata), .cnt_o(mcyc)
  );

  vx_csr_counter64 #(.INC_W(CC_WIDTH)) u_minstret (
    .clk(clk), .reset(reset), .inc_i(commit_valid ? commit_count : '0),
    .wr_lo_i(ins_wlo), .wr_hi_i(ins_whi), .wdata_i(cnt_wdata), .cnt_o(mins)
  );

  logic [NUM_WARPS-1:0][NUM_THREADS-1:0][XLEN-1:0] mscr_q, mscr_d;

  // Each enabled lane writes its own thread's mscratch slot.
  always_comb begin
    mscr_d = mscr_q;
    if (csr_if.write_enable && waddr == CSR_MSCRATCH)
      for (int l = 0; l < NUM_LANES; l++)
        if (csr_if.write_tmask[l])
          mscr_d[csr_if.write_wid][TID_W'(int'(csr_if.write_pid) * NUM_LANES + l)] = csr_if.write_data[l];
  end

  // mscratch storage register.
  always_ff @(posedge clk) begin
    if (!reset) mscr_q <= '0;
    else        mscr_q <= mscr_d;
  end

`ifdef SFU_CSR_FCSR_EN
  fflags_t [NUM_WARPS-1:0]                ff_q, ff_d;
  logic    [NUM_WARPS-1:0][FRM_BITS-1:0]  frm_q, frm_d;

  // CSR write first, then OR in FPU flags so a same-cycle exception is never lost.
  always_comb begin
    ff_d  = ff_q;
    frm_d = frm_q;
    if (wr_any) begin
      case (waddr)
        CSR_FFLAGS: ff_d[csr_if.write_wid] = fflags_t'(wsel_data[4:0]);
        CSR_FRM:    frm_d[csr_if.write_wid] = wsel_data[FRM_BITS-1:0];
        CSR_FCSR: begin
          frm_d[csr_if.write_wid] = wsel_data[7:5];
          ff_d[csr_if.write_wid]  = fflags_t'(wsel_data[4:0]);
        end
        default: ;
      endcase
    end
    if (fpu_fflags_valid)
      ff_d[fpu_fflags_wid] = fflags_t'(ff_d[fpu_fflags_wid] | fflags_t'(fpu_fflags));
  end

  // FP status registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ff_q  <= '0;
      frm_q <= '0;
    end else begin
      ff_q  <= ff_d;
      frm_q <= frm_d;
    end
  end

  assign rd_ff     = ff_q[csr_if.read_wid];
  assign rd_frm    = frm_q[csr_if.read_wid];
  assign unused_ok = ^{csr_if.read_uuid, csr_if.write_uuid};
`else
  assign rd_ff     = '0;
  assign rd_frm    = '0;
  assign unused_ok = ^{csr_if.read_uuid, csr_if.write_uuid,
                       fpu_fflags_valid, fpu_fflags_wid, fpu_fflags};
`endif

  // Values common to every enabled lane of the read.
  always_comb begin
    shared_rd = '0;
    case (raddr)
      CSR_FFLAGS:                  shared_rd = XLEN'(rd_ff);
      CSR_FRM:                     shared_rd = XLEN'(rd_frm);
      CSR_FCSR:                    shared_rd = XLEN'({rd_frm, rd_ff});
      CSR_MCYCLE, CSR_CYCLE:       shared_rd = mcyc[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH:     shared_rd = X32 ? XLEN'(mcyc[63:32]) : '0;
      CSR_MINSTRET, CSR_INSTRET:   shared_rd = mins[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: shared_rd = X32 ? XLEN'(mins[63:32]) : '0;
      CSR_WARP_ID:                 shared_rd = XLEN'(csr_if.read_wid);
      CSR_CORE_ID:                 shared_rd = XLEN'(CORE_ID);
      CSR_ACTIVE_WARPS:            shared_rd = XLEN'(active_warps);
      default:                     shared_rd = '0;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [XLEN-1:0] rd;
    int              tid;

    assign tid = int'(csr_if.read_pid) * NUM_LANES + l;

    // Per-lane read mux; disabled lanes, idle reads and reset all return zero.
    always_comb begin
      rd = '0;
      if (reset && csr_if.read_enable && csr_if.read_tmask[l]) begin
        case (raddr)
          CSR_MSCRATCH:  rd = mscr_q[csr_if.read_wid][TID_W'(tid)];
          CSR_THREAD_ID: rd = XLEN'(tid);
          default:       rd = shared_rd;
        endcase
      end
    end

    assign csr_if.read_data[l] = rd;
  end
endmodule

// File: doc/vx_sfu_csr_responder.md
# vx_sfu_csr_responder

Slave-side CSR responder for the SFU CSR interface. It answers per-lane CSR reads and applies CSR writes issued by the SFU CSR master. It holds the per-core machine counters (cycle, instret), per-thread `mscratch`, and per-warp floating-point status, and it synthesises the read-only identity CSRs. It sits in the core next to the SFU and is the only sink of `VX_sfu_csr_if.slave` in the core.

## Interface
Parameters:
- `CORE_ID`, 0: value returned by the core-id CSR.
- `NUM_LANES`, `NUM_SFU_LANES`: lanes per CSR request.
- `PID_WIDTH`, `LOG2UP(NUM_THREADS/NUM_LANES)`: packet-id width; thread index = pid*NUM_LANES + lane.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `csr_if` slave `VX_sfu_csr_if`: read_enable/uuid/wid/tmask/pid/addr in, read_data out; write_* in.
- `commit_valid` in 1: instructions retired this cycle.
- `commit_count` in `LOG2UP(NUM_THREADS)+1`: number retired (warp-level count).
- `fpu_fflags_valid` in 1: FPU reports exception flags.
- `fpu_fflags_wid` in `NW_WIDTH`: warp of the reported flags.
- `fpu_fflags` in 5: NV, DZ, OF, UF, NX.
- `active_warps` in `NUM_WARPS`: warp active mask, read through a CSR.

## Operation
Address map (in `VX_gpu_pkg`):
- fflags 0x001, frm 0x002, fcsr 0x003: per warp.
- mscratch 0x340: per thread.
- mcycle 0xB00 / mcycleh 0xB80, minstret 0xB02 / minstreth 0xB82: per core, read-write.
- cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases.
- thread_id 0xCC0, warp_id 0xCC1, core_id 0xCC2, active_warps 0xCC3: read-only.

Reads:
- Lanes with tmask=0 return 0.
- Per-thread CSRs index `[wid][pid*NUM_LANES+lane]`.
- Per-warp and per-core values are replicated to all enabled lanes.
- thread_id returns pid*NUM_LANES+lane.
- The `*h` halves return bits [63:32] when XLEN=32 and 0 when XLEN=64. The full counter is returned on the low address.
- Unmapped addresses, and all reads while `read_enable`=0, return 0.

Writes:
- Per-thread CSRs: every lane with tmask=1 writes its own data.
- Per-warp and per-core CSRs take data from the lowest set lane of `write_tmask`. A tmask of all zeros is a no-op.
- Writes to read-only or unmapped addresses are silently dropped.
- fcsr write: frm = data[7:5], fflags = data[4:0]. Higher bits are ignored.

Counters:
- mcycle increments by 1 every cycle while out of reset.
- minstret adds `commit_count` when `commit_valid` is high.
- A CSR write to a counter (either half) replaces that half and suppresses the increment for that cycle. The other half holds.
- Counters wrap modulo 2^64.

fflags accumulation:
- When `fpu_fflags_valid` is high, the reported flags are ORed into fflags[`fpu_fflags_wid`].
- If a CSR write to fflags or fcsr targets the same warp in the same cycle, the new value is write_data[4:0] | fpu_fflags. The CSR write does not lose concurrent exceptions.

## Timing
- Read is combinational: `read_data` is valid in the same cycle as `read_enable`.
- A write issued in cycle t is visible to a read at t+1. A read at t of the address written at t returns the old value.
- A counter read in cycle t returns the value registered before edge t. mcycle therefore reads N-1 in the N-th cycle after reset deassert.
- Reset (`reset`=0), including mid-operation:
  - all counters, mscratch, fflags and frm go to 0;
  - writes and increments are ignored;
  - `read_data` is driven to 0.
- No backpressure: the slave accepts one read and one write every cycle, to independent addresses or the same address.

## Configuration
- `SFU_CSR_FCSR_EN` defined: per-warp fflags/frm storage and FPU accumulation are present.
- Not defined:
  - 0x001–0x003 read 0 and writes are dropped;
  - the `fpu_fflags*` ports remain but are ignored;
  - no fflags/frm storage is instantiated.

## Structure
- `VX_gpu_pkg` holds the CSR address constants, the 5-bit fflags struct typedef, and the frm width constant.
- Sub-module `vx_csr_counter64`: 64-bit counter with increment input, per-half write enables, write data and synchronous active-low reset. It is instantiated twice, for mcycle and minstret.

## Test plan
- Reset, then 10 cycles, then read mcycle → returns 9 (XLEN=32: mcycleh returns 0).
- Write mcycleh=0x1, mcycle=0xFFFFFFFF in separate cycles, then idle one cycle → the 64-bit value has carried to 0x2_00000000 (+elapsed cycles).
- Write mscratch with tmask=0b0101, wid=2, pid=1, data lane0=0xA, lane2=0xC → the next read (tmask=all) returns 0xA, 0, 0xC, 0. Reading wid=1 returns all 0.
- Same cycle: FPU flags 0b00001 for wid 3 and CSR write fflags=0b10000 for wid 3 → fflags reads 0b10001. With `SFU_CSR_FCSR_EN` undefined, it reads 0.
- Read thread_id with pid=1 (NUM_LANES=4), tmask=0b1111 → returns 4, 5, 6, 7. Write to thread_id, then read → unchanged.
- Assert `reset`=0 for one cycle mid-run after minstret accumulated 50 → next read returns 0. read_data is 0 during the reset cycle.
